// File: rtl/imm_stage_pkg.sv
// Shared constants for the immediate-generation stage.
//   - Bit positions of the one-hot instruction-format vector.
//   - Encoding of the two-entry skid buffer occupancy.
//   - One-hot test helper used by the decoder.
package imm_stage_pkg;

    localparam int FMT_W    = 8;
    localparam int FMT_R    = 0;
    localparam int FMT_I    = 1;
    localparam int FMT_S    = 2;
    localparam int FMT_B    = 3;
    localparam int FMT_U    = 4;
    localparam int FMT_J    = 5;
    localparam int FMT_SHMT = 6;
    localparam int FMT_ZIMM = 7;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    function automatic logic is_onehot(input logic [FMT_W-1:0] f);
        return (f != '0) && ((f & (f - FMT_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/imm_stage_if.sv
// Handshake bundle between an instruction source, imm_stage and its consumer.
//   Input side : i_valid / o_ready, i_inst, i_format (one-hot), i_tag
//   Output side: o_valid / i_ready, o_immediate, o_tag, o_fmt_err, o_err_count
// slave  : view taken by imm_stage
// master : view taken by the environment driving and consuming it
interface imm_stage_if
    import imm_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int TAGW = 5,
    parameter int ERRW = 8
);
    logic             i_valid;
    logic             o_ready;
    logic [31:0]      i_inst;
    logic [FMT_W-1:0] i_format;
    logic [TAGW-1:0]  i_tag;
    logic             o_valid;
    logic             i_ready;
    logic [XLEN-1:0]  o_immediate;
    logic [TAGW-1:0]  o_tag;
    logic             o_fmt_err;
    logic [ERRW-1:0]  o_err_count;

    modport slave (
        input  i_valid, i_inst, i_format, i_tag, i_ready,
        output o_ready, o_valid, o_immediate, o_tag, o_fmt_err, o_err_count
    );

    modport master (
        output i_valid, i_inst, i_format, i_tag, i_ready,
        input  o_ready, o_valid, o_immediate, o_tag, o_fmt_err, o_err_count
    );
endinterface

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate decoder.
//   inst    : instruction bits [31:7] (the opcode field carries no immediate bits)
//   fmt     : one-hot format select (bit positions from imm_stage_pkg)
//   imm     : decoded immediate, XLEN wide (32 or 64)
//   fmt_err : fmt was zero or multi-hot; imm is forced to zero in that case
module imm_decode
    import imm_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]      inst,
    input  logic [FMT_W-1:0] fmt,
    output logic [XLEN-1:0]  imm,
    output logic             fmt_err
);

    // Every format is first assembled as a 32-bit value; sext selects whether
    // widening to XLEN replicates bit 31 or pads with zeros.
    logic signed [31:0] raw;
    logic               sext;

    always_comb begin
        raw     = '0;
        sext    = 1'b1;
        fmt_err = !is_onehot(fmt);
        if (!fmt_err) begin
            if (fmt[FMT_I]) begin
                raw = {{20{inst[31]}}, inst[31:20]};
            end else if (fmt[FMT_S]) begin
                raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end else if (fmt[FMT_B]) begin
                raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end else if (fmt[FMT_U]) begin
                raw = {inst[31:12], 12'h000};
            end else if (fmt[FMT_J]) begin
                raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end else if (fmt[FMT_SHMT]) begin
                // RV64 shift amounts use one more bit than RV32.
                sext = 1'b0;
                raw  = {26'd0, (XLEN == 64) ? inst[25] : 1'b0, inst[24:20]};
            end else if (fmt[FMT_ZIMM]) begin
                sext = 1'b0;
                raw  = {27'd0, inst[19:15]};
            end
            // R-type keeps the all-zero default.
        end
    end

    assign imm = sext ? XLEN'(raw) : XLEN'($unsigned(raw));

endmodule

// File: rtl/imm_stage.sv
// Immediate-generation pipeline stage with a two-entry skid buffer.
//   i_clk   : clock, all state on the rising edge
//   i_rst_n : synchronous active-low reset
//   bus     : imm_stage_if.slave -- valid/ready input of instruction, format
//             and tag; valid/ready output of immediate, tag, format-error
//             flag and saturating count of malformed formats accepted.
// An accepted input is decoded before it is stored, so the result is visible
// the cycle after acceptance. o_ready only drops when both entries are full,
// which keeps it free of any combinational path from i_ready.
module imm_stage
    import imm_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int TAGW = 5,
    parameter int ERRW = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    imm_stage_if.slave  bus
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [TAGW-1:0] tag;
        logic            err;
    } entry_t;

    function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
        return (&v) ? v : v + ERRW'(1);
    endfunction

    state_t          state, state_nxt;
    logic            ready, valid;
    logic            in_xfer, out_xfer;
    logic [XLEN-1:0] dec_imm;
    logic            dec_err;
    entry_t          dec_p0;
    entry_t          head_p1;
    entry_t          spare_p1;
    logic [ERRW-1:0] err_cnt;

    // Stage 0: decode the offered instruction
    imm_decode #(.XLEN(XLEN)) u_decode (
        .inst    (bus.i_inst[31:7]),
        .fmt     (bus.i_format),
        .imm     (dec_imm),
        .fmt_err (dec_err)
    );

    assign dec_p0   = '{imm: dec_imm, tag: bus.i_tag, err: dec_err};
    assign in_xfer  = bus.i_valid && ready;
    assign out_xfer = valid && bus.i_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (in_xfer) state_nxt = ST_ONE;
            ST_ONE: begin
                if (in_xfer && !out_xfer) begin
                    state_nxt = ST_TWO;
                end else if (out_xfer && !in_xfer) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO:   if (out_xfer) state_nxt = ST_ONE;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    always_comb begin
        ready = (state != ST_TWO);
        valid = (state == ST_ONE) || (state == ST_TWO);
    end

    // Stage 1: buffered results; head_p1 is always the oldest entry
    always_ff @(posedge i_clk) begin
        case (state)
            ST_EMPTY: if (in_xfer) head_p1 <= dec_p0;
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    head_p1 <= dec_p0;
                end else if (in_xfer) begin
                    spare_p1 <= dec_p0;
                end
            end
            ST_TWO:   if (out_xfer) head_p1 <= spare_p1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            err_cnt <= '0;
        end else if (in_xfer && dec_err) begin
            err_cnt <= sat_inc(err_cnt);
        end
    end

    // Payload registers are not reset; gating with valid keeps stale or
    // uninitialised contents off the outputs.
    assign bus.o_ready     = ready;
    assign bus.o_valid     = valid;
    assign bus.o_immediate = valid ? head_p1.imm : '0;
    assign bus.o_tag       = valid ? head_p1.tag : '0;
    assign bus.o_fmt_err   = valid && head_p1.err;
    assign bus.o_err_count = err_cnt;

endmodule

// File: tb/tb_imm_stage.sv
// Bench for imm_stage: an RV32 instance (ERRW=8) and an RV64 instance
// (ERRW=2) run in lockstep from one shared stimulus stream.
module tb_imm_stage;
    import imm_stage_pkg::*;

    localparam int TAGW = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            valid;
    logic            rdy;
    logic [31:0]     inst;
    logic [7:0]      fmt;
    logic [TAGW-1:0] tag;

    always #5 clk = ~clk;

    imm_stage_if #(.XLEN(32), .TAGW(TAGW), .ERRW(8)) bus32 ();
    imm_stage_if #(.XLEN(64), .TAGW(TAGW), .ERRW(2)) bus64 ();

    assign bus32.i_valid  = valid;
    assign bus32.i_inst   = inst;
    assign bus32.i_format = fmt;
    assign bus32.i_tag    = tag;
    assign bus32.i_ready  = rdy;
    assign bus64.i_valid  = valid;
    assign bus64.i_inst   = inst;
    assign bus64.i_format = fmt;
    assign bus64.i_tag    = tag;
    assign bus64.i_ready  = rdy;

    imm_stage #(.XLEN(32), .TAGW(TAGW), .ERRW(8)) u32 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus32)
    );

    imm_stage #(.XLEN(64), .TAGW(TAGW), .ERRW(2)) u64 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus64)
    );

    typedef struct {
        logic [31:0]     imm32;
        logic [63:0]     imm64;
        logic [TAGW-1:0] tag;
        logic            err;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_mis = 0;
    int   exp_e32 = 0;
    int   exp_e64 = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] w, input logic [7:0] f, input int xl);
        logic [63:0] r;
        case (f)
            8'h02:   r = {{52{w[31]}}, w[31:20]};
            8'h04:   r = {{52{w[31]}}, w[31:25], w[11:7]};
            8'h08:   r = {{51{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            8'h10:   r = {{32{w[31]}}, w[31:12], 12'h000};
            8'h20:   r = {{43{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            8'h40:   r = (xl == 64) ? {58'd0, w[25:20]} : {59'd0, w[24:20]};
            8'h80:   r = {59'd0, w[19:15]};
            default: r = 64'd0;
        endcase
        if (xl == 32) r = {32'd0, r[31:0]};
        return r;
    endfunction

    // Scoreboard: compare occupancy, head entry and counters every cycle,
    // pop on output transfer, push on input transfer.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
            exp_e32 = 0;
            exp_e64 = 0;
        end else begin
            chk("valid32", 64'(bus32.o_valid), 64'(q.size() != 0));
            chk("valid64", 64'(bus64.o_valid), 64'(q.size() != 0));
            chk("ready32", 64'(bus32.o_ready), 64'(q.size() < 2));
            chk("ready64", 64'(bus64.o_ready), 64'(q.size() < 2));
            chk("errcnt32", 64'(bus32.o_err_count), 64'(exp_e32));
            chk("errcnt64", 64'(bus64.o_err_count), 64'(exp_e64));
            if (bus32.o_valid && q.size() != 0) begin
                e = q[0];
                chk("imm32", 64'(bus32.o_immediate), 64'(e.imm32));
                chk("imm64", bus64.o_immediate, e.imm64);
                chk("tag32", 64'(bus32.o_tag), 64'(e.tag));
                chk("tag64", 64'(bus64.o_tag), 64'(e.tag));
                chk("fmterr32", 64'(bus32.o_fmt_err), 64'(e.err));
                chk("fmterr64", 64'(bus64.o_fmt_err), 64'(e.err));
                if (rdy) q.pop_front();
            end
            if (valid && bus32.o_ready) begin
                e.imm32 = 32'(model(inst, fmt, 32));
                e.imm64 = model(inst, fmt, 64);
                e.tag   = tag;
                e.err   = ($countones(fmt) != 1);
                q.push_back(e);
                if (e.err) begin
                    if (exp_e32 < 255) exp_e32++;
                    if (exp_e64 < 3)   exp_e64++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [31:0] i, input logic [7:0] f, input logic [TAGW-1:0] t);
        int budget = 20;
        valid = 1'b1;
        inst  = i;
        fmt   = f;
        tag   = t;
        @(negedge clk);
        while (!bus32.o_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        n_vec++;
        assert (budget > 0)
        else begin
            n_mis++;
            $error("FAIL send_timeout tag=%0d observed=no_accept expected=accept", t);
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
        inst  = $urandom;
        fmt   = 8'($urandom);
    endtask

    task automatic send_chk(input string name, input logic [31:0] i, input logic [7:0] f,
                            input logic [31:0] e32, input logic [63:0] e64, input logic e_err);
        step();
        send(i, f, 5'd7);
        @(negedge clk);
        chk({name, "_lat"}, 64'(bus32.o_valid), 64'd1);
        chk({name, "_32"}, 64'(bus32.o_immediate), 64'(e32));
        chk({name, "_64"}, bus64.o_immediate, e64);
        chk({name, "_err"}, 64'(bus32.o_fmt_err), 64'(e_err));
    endtask

    task automatic drain();
        int b = 30;
        while (q.size() != 0 && b > 0) begin
            @(posedge clk);
            b--;
        end
        n_vec++;
        assert (b > 0)
        else begin
            n_mis++;
            $error("FAIL drain pending=%0d expected=0", q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        valid = 1'b0;
        rdy   = 1'b0;
        inst  = '0;
        fmt   = '0;
        tag   = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", 64'(bus32.o_valid), 64'd0);
        chk("rst_ready", 64'(bus32.o_ready), 64'd1);
        chk("rst_imm32", 64'(bus32.o_immediate), 64'd0);
        chk("rst_imm64", bus64.o_immediate, 64'd0);
        chk("rst_tag", 64'(bus32.o_tag), 64'd0);
        chk("rst_fmterr", 64'(bus32.o_fmt_err), 64'd0);
        chk("rst_errcnt", 64'(bus32.o_err_count), 64'd0);

        rdy = 1'b1;
        send_chk("i_type", 32'hFFF00093, 8'h02, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        send_chk("b_type", 32'hFE000EE3, 8'h08, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        send_chk("j_type", 32'h0080006F, 8'h20, 32'h00000008, 64'h0000000000000008, 1'b0);
        send_chk("u_type", 32'h80000037, 8'h10, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0);
        send_chk("shamt",  32'h03F01013, 8'h40, 32'h0000001F, 64'h000000000000003F, 1'b0);
        send_chk("s_type", 32'hFE000E23, 8'h04, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        send_chk("zimm",   32'hFFFF8073, 8'h80, 32'h0000001F, 64'h000000000000001F, 1'b0);
        send_chk("r_type", 32'hFFFFFFFF, 8'h01, 32'h00000000, 64'h0000000000000000, 1'b0);
        send_chk("multihot", 32'hFFF00093, 8'h06, 32'h00000000, 64'h0000000000000000, 1'b1);
        send_chk("zerohot",  32'hFFF00093, 8'h00, 32'h00000000, 64'h0000000000000000, 1'b1);
        @(negedge clk);
        chk("errcnt2_32", 64'(bus32.o_err_count), 64'd2);
        chk("errcnt2_64", 64'(bus64.o_err_count), 64'd2);

        for (int k = 0; k < 3; k++) begin
            send_chk("err_more", 32'h12345678, 8'hFF, 32'h0, 64'h0, 1'b1);
        end
        @(negedge clk);
        chk("errcnt5_32", 64'(bus32.o_err_count), 64'd5);
        chk("errcnt_sat64", 64'(bus64.o_err_count), 64'd3);

        // Stall: three tags offered back-to-back while the consumer holds off
        step();
        rdy = 1'b0;
        send(32'h00100093, 8'h02, 5'd1);
        send(32'h00200093, 8'h02, 5'd2);
        fork
            send(32'h00300093, 8'h02, 5'd3);
            begin
                @(negedge clk);
                chk("stall_ready32", 64'(bus32.o_ready), 64'd0);
                chk("stall_ready64", 64'(bus64.o_ready), 64'd0);
                repeat (3) @(posedge clk);
                #1 rdy = 1'b1;
            end
        join
        drain();

        // Reset while both entries are occupied
        step();
        rdy = 1'b0;
        send(32'h01400093, 8'h02, 5'd20);
        send(32'h01500093, 8'h02, 5'd21);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst2_valid", 64'(bus32.o_valid), 64'd0);
        chk("rst2_ready", 64'(bus32.o_ready), 64'd1);
        chk("rst2_errcnt32", 64'(bus32.o_err_count), 64'd0);
        chk("rst2_errcnt64", 64'(bus64.o_err_count), 64'd0);
        rdy = 1'b1;
        step();
        send(32'h01600093, 8'h02, 5'd22);
        @(negedge clk);
        chk("post_rst_tag", 64'(bus32.o_tag), 64'd22);
        drain();
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
